// File: rtl/alu_addseq_pkg.sv
// Shared encodings for the multi-byte add/subtract sequencer.
package alu_addseq_pkg;

  localparam int DATASIZE_DEF = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_ADC = 3'b001,
    OP_SUB = 3'b010,
    OP_SBB = 3'b011,
    OP_INC = 3'b100,
    OP_DEC = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/add8b.sv
// Ripple adder slice; per-bit carry outputs, carry-in either chained or per-bit external.
module add8b #(
  parameter int DATASIZE = 8,
  parameter bit USE_EXTC = 1'b0
) (
  input  logic [DATASIZE-1:0] iA,
  input  logic [DATASIZE-1:0] iB,
  input  logic [DATASIZE-1:0] iC,
  output logic [DATASIZE-1:0] oS,
  output logic [DATASIZE-1:0] oC
);

  always_comb begin
    logic w_c;
    oS  = '0;
    oC  = '0;
    w_c = iC[0];
    for (int i = 0; i < DATASIZE; i++) begin
      if (i != 0 && USE_EXTC) w_c = iC[i];
      oS[i] = iA[i] ^ iB[i] ^ w_c;
      w_c   = (iA[i] & iB[i]) | (w_c & (iA[i] ^ iB[i]));
      oC[i] = w_c;
    end
  end

endmodule

// File: rtl/alu_addseq.sv
// Multi-cycle register-pair add/subtract: one adder slice stepped LSB-first over the operand bytes.
//   state | meaning
//   IDLE  | waiting for iReq
//   RUN   | one operand byte per cycle, carry chained through r_carry
//   DONE  | oDone pulse; results published; may accept the next request
module alu_addseq
  import alu_addseq_pkg::*;
#(
  parameter int DATASIZE  = DATASIZE_DEF,
  parameter int WORDBYTES = 2
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iReq,
  input  logic [2:0]                    iOp,
  input  logic [DATASIZE*WORDBYTES-1:0] iA,
  input  logic [DATASIZE*WORDBYTES-1:0] iB,
  input  logic                          iCin,
  output logic                          oBusy,
  output logic                          oDone,
  output logic [DATASIZE*WORDBYTES-1:0] oRes,
  output logic                          oCarry,
  output logic                          oZero
);

  localparam int W  = DATASIZE * WORDBYTES;
  localparam int IW = (WORDBYTES > 1) ? $clog2(WORDBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDBYTES - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                w_accept;
  logic                w_last;
  logic [IW-1:0]       r_idx;
  logic [2:0]          r_op;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic                r_cin;
  logic                r_carry;
  logic [W-1:0]        r_acc;
  logic                r_zacc;
  logic [W-1:0]        r_res;
  logic                r_cout;
  logic                r_zero;

  logic [DATASIZE-1:0] w_a_byte;
  logic [DATASIZE-1:0] w_b_raw;
  logic [DATASIZE-1:0] w_b_byte;
  logic                w_c0;
  logic                w_slice_cin;
  logic                w_borrow_op;
  logic [DATASIZE-1:0] w_sum;
  logic [DATASIZE-1:0] w_slice_c;
  logic                w_cout;
  logic [W-1:0]        w_acc_nxt;
  logic                w_zacc_nxt;
  logic                w_unused_c;

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iReq) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_idx == LAST_IDX) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_accept    = iReq;
        w_state_nxt = iReq ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_last = (r_state == ST_RUN) && (r_idx == LAST_IDX);

  // Operand conditioning: subtracts become A + ~B + c0, INC/DEC use constant B bytes.
  always_comb begin
    w_a_byte    = r_a[r_idx*DATASIZE +: DATASIZE];
    w_b_raw     = r_b[r_idx*DATASIZE +: DATASIZE];
    w_b_byte    = w_b_raw;
    w_c0        = 1'b0;
    w_borrow_op = 1'b0;
    case (r_op)
      OP_ADC: w_c0 = r_cin;
      OP_SUB: begin
        w_b_byte    = ~w_b_raw;
        w_c0        = 1'b1;
        w_borrow_op = 1'b1;
      end
      OP_SBB: begin
        w_b_byte    = ~w_b_raw;
        w_c0        = ~r_cin;
        w_borrow_op = 1'b1;
      end
      OP_INC: begin
        w_b_byte = '0;
        w_c0     = 1'b1;
      end
      OP_DEC: begin
        w_b_byte    = '1;
        w_borrow_op = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_slice_cin = (r_idx == '0) ? w_c0 : r_carry;

  add8b #(
    .DATASIZE (DATASIZE),
    .USE_EXTC (1'b0)
  ) u_add8b (
    .iA (w_a_byte),
    .iB (w_b_byte),
    .iC ({{(DATASIZE-1){1'b0}}, w_slice_cin}),
    .oS (w_sum),
    .oC (w_slice_c)
  );

  assign w_cout     = w_slice_c[DATASIZE-1];
  assign w_unused_c = ^w_slice_c;

  always_comb begin
    w_acc_nxt = r_acc;
    w_acc_nxt[r_idx*DATASIZE +: DATASIZE] = w_sum;
    w_zacc_nxt = ((r_idx == '0) ? 1'b1 : r_zacc) & (w_sum == '0);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_idx   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_zacc  <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_idx <= '0;
      r_op  <= iOp;
      r_a   <= iA;
      r_b   <= iB;
      r_cin <= iCin;
    end else if (r_state == ST_RUN) begin
      r_idx   <= r_idx + IW'(1);
      r_carry <= w_cout;
      r_acc   <= w_acc_nxt;
      r_zacc  <= w_zacc_nxt;
      // Publish only the completed word so outputs never mix two operations.
      if (w_last) begin
        r_res  <= w_acc_nxt;
        r_cout <= w_cout ^ w_borrow_op;
        r_zero <= w_zacc_nxt;
      end
    end
  end

  assign oBusy  = (r_state == ST_RUN);
  assign oDone  = (r_state == ST_DONE);
  assign oRes   = r_res;
  assign oCarry = r_cout;
  assign oZero  = r_zero;

endmodule

// File: tb/tb_alu_addseq.sv
// Directed and random checks of alu_addseq (WORDBYTES=2) against a 17-bit arithmetic model.
module tb_alu_addseq;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iReq = 1'b0;
  logic [2:0]  iOp  = 3'd0;
  logic [15:0] iA   = 16'd0;
  logic [15:0] iB   = 16'd0;
  logic        iCin = 1'b0;
  logic        oBusy, oDone, oCarry, oZero;
  logic [15:0] oRes;

  int checks = 0;
  int errors = 0;

  alu_addseq #(.DATASIZE(8), .WORDBYTES(2)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iOp(iOp), .iA(iA), .iB(iB),
    .iCin(iCin), .oBusy(oBusy), .oDone(oDone), .oRes(oRes),
    .oCarry(oCarry), .oZero(oZero)
  );

  always #5 iClk = ~iClk;

  // Bit 16 is the carry for add-type ops and the borrow for subtract-type ops.
  function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    logic [16:0] s;
    case (op)
      3'd1:    s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      3'd2:    s = {1'b0, a} - {1'b0, b};
      3'd3:    s = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      3'd4:    s = {1'b0, a} + 17'd1;
      3'd5:    s = {1'b0, a} - 17'd1;
      default: s = {1'b0, a} + {1'b0, b};
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin);
    iReq = 1'b1; iOp = op; iA = a; iB = b; iCin = cin;
  endtask

  // Called on a falling edge; returns on the falling edge of the DONE cycle (or timeout).
  task automatic wait_done(input string tag, input bit hold_req, output int lat, output int busy);
    bit overlap = 0;
    lat  = 0;
    busy = 0;
    @(posedge iClk);
    do begin
      @(negedge iClk);
      lat++;
      if (!hold_req) iReq = 1'b0;
      if (oBusy) busy++;
      if (oBusy && oDone) overlap = 1;
    end while (!oDone && lat < 10);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_busy"}, busy, 2);
    chk({tag, "_overlap"}, {31'd0, overlap}, 0);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic [15:0] exp_res,
                       input logic exp_c, input logic exp_z);
    int lat, busy;
    present(op, a, b, cin);
    wait_done(tag, 1'b0, lat, busy);
    chk({tag, "_res"}, {16'd0, oRes}, {16'd0, exp_res});
    chk({tag, "_carry"}, {31'd0, oCarry}, {31'd0, exp_c});
    chk({tag, "_zero"}, {31'd0, oZero}, {31'd0, exp_z});
    @(negedge iClk);
  endtask

  task automatic do_rand(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
    logic [16:0] m;
    m = model(op, a, b, cin);
    do_op(tag, op, a, b, cin, m[15:0], m[16], m[15:0] == 16'd0);
  endtask

  initial begin
    int lat, busy, ndone;
    logic [16:0] m;

    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    chk("rst_busy", {31'd0, oBusy}, 0);
    chk("rst_done", {31'd0, oDone}, 0);
    chk("rst_res", {16'd0, oRes}, 0);
    chk("rst_flags", {30'd0, oCarry, oZero}, 0);

    do_op("add_a",  3'd0, 16'h12FF, 16'h0001, 1'b0, 16'h1300, 1'b0, 1'b0);
    do_op("add_b",  3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op("adc",    3'd1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    do_op("sub_a",  3'd2, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    do_op("sub_b",  3'd2, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    do_op("sbb",    3'd3, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    do_op("inc",    3'd4, 16'h00FF, 16'h1234, 1'b1, 16'h0100, 1'b0, 1'b0);
    do_op("dec_a",  3'd5, 16'h0000, 16'h5555, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    do_op("dec_b",  3'd5, 16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1);
    do_op("rsv",    3'd7, 16'h8001, 16'h8001, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Back-to-back: iReq held, new op presented in the DONE cycle.
    present(3'd0, 16'h0102, 16'h0304, 1'b0);
    wait_done("b2b1", 1'b1, lat, busy);
    chk("b2b1_res", {16'd0, oRes}, 32'h0406);
    present(3'd2, 16'h0300, 16'h0001, 1'b0);
    lat = 0;
    do begin
      @(negedge iClk);
      lat++;
    end while (!oDone && lat < 10);
    chk("b2b_spacing", lat, 3);
    chk("b2b2_res", {16'd0, oRes}, 32'h02FF);
    iReq = 1'b0;
    @(negedge iClk);
    @(negedge iClk);

    // Request pulse during RUN must be ignored.
    present(3'd4, 16'h7FFF, 16'h0000, 1'b0);
    @(posedge iClk);
    @(negedge iClk);
    present(3'd0, 16'h1111, 16'h2222, 1'b0);
    @(negedge iClk);
    iReq  = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (oDone) ndone++;
      @(negedge iClk);
    end
    chk("runreq_ndone", ndone, 1);
    chk("runreq_res", {16'd0, oRes}, 32'h8000);
    chk("runreq_busy", {31'd0, oBusy}, 0);

    // Reset in the second RUN cycle discards the operation.
    present(3'd0, 16'h0F0F, 16'h0101, 1'b0);
    @(posedge iClk);
    @(negedge iClk);
    iReq = 1'b0;
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    chk("mrst_busy", {31'd0, oBusy}, 0);
    chk("mrst_done", {31'd0, oDone}, 0);
    chk("mrst_res", {16'd0, oRes}, 0);
    chk("mrst_flags", {30'd0, oCarry, oZero}, 0);
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      if (oDone || oBusy) ndone++;
      @(negedge iClk);
    end
    chk("mrst_idle", ndone, 0);
    do_op("post_rst", 3'd1, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      logic [15:0] a, b;
      logic        c;
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      c  = 1'($urandom);
      if (n % 8 == 0) a = 16'hFFFF;
      if (n % 8 == 1) b = a;
      m = model(op, a, b, c);
      do_rand($sformatf("rnd%0d_op%0d", n, op), op, a, b, c);
      if (m[15:0] == 16'd0) @(negedge iClk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
